// File: rtl/node_rx_collector.sv
// node_rx_collector: receive-side operand collector.
// It accepts one packet at a time over a req/ack handshake and unpacks payload
// beats 0..2 into operands A/B/C. The operand set is held for the PE under
// valid/ready. Packets with a bad length or a stalled transfer are discarded
// and flagged with a one-cycle pulse.
// Optional feature: define NODE_RX_ERR_CNT_EN to build the saturating error counter.
module node_rx_collector #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        N_clk,
    input  logic        N_rst,
    input  logic        rx_req,
    output logic        rx_ack,
    input  logic [63:0] rx_data,
    input  logic        rx_data_valid,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [31:0] op_c,
    output logic [7:0]  op_src,
    output logic [5:0]  op_id,
    output logic        op_valid,
    input  logic        op_ready,
    output logic        err_len,
    output logic        err_timeout,
    output logic [7:0]  err_count
);

    localparam int unsigned OP_W  = 32;
    localparam int unsigned SRC_W = 8;
    localparam int unsigned LEN_W = 6;
    localparam int unsigned ID_W  = 6;
    localparam int unsigned TMR_W = 8;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_RECV = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   beat_cnt;
    logic [TMR_W-1:0]   timer;
    logic [OP_W-1:0]    stg_a;
    logic [OP_W-1:0]    stg_b;
    logic [SRC_W-1:0]   stg_src;
    logic [LEN_W-1:0]   stg_len;
    logic [ID_W-1:0]    stg_id;

    logic [SRC_W-1:0]   hdr_src;
    logic [LEN_W-1:0]   hdr_len;
    logic [ID_W-1:0]    hdr_id;
    logic [OP_W-1:0]    payload;
    logic [LEN_W-1:0]   eff_len;
    logic               last_beat;
    logic               timed_out;
    logic               unused_rsvd;

    logic               ack_nxt;
    logic               err_len_nxt;
    logic               err_tmo_nxt;
    logic               load_op;
    logic               take_beat;
    logic               clr_cnt;

    // Beat field split; reserved bits carry nothing of interest.
    assign hdr_src     = rx_data[63:56];
    assign hdr_len     = rx_data[55:50];
    assign hdr_id      = rx_data[49:44];
    assign payload     = rx_data[31:0];
    assign unused_rsvd = ^rx_data[43:32];

    // Beat 0 supplies the length directly; later beats use the staged header.
    assign eff_len   = (beat_cnt == '0) ? hdr_len : stg_len;
    assign last_beat = (eff_len == '0) || (beat_cnt == eff_len - LEN_W'(1));
    assign timed_out = !rx_data_valid && (timer == TMR_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; a held operand set withholds the acknowledge.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (rx_req && !op_valid) state_nxt = S_ACK;
            S_ACK:  state_nxt = S_RECV;
            S_RECV: begin
                if (rx_data_valid && last_beat) state_nxt = S_IDLE;
                else if (timed_out)             state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output/control decode feeding the registered outputs and datapath.
    always_comb begin
        ack_nxt     = 1'b0;
        err_len_nxt = 1'b0;
        err_tmo_nxt = 1'b0;
        load_op     = 1'b0;
        take_beat   = 1'b0;
        clr_cnt     = 1'b0;
        case (state)
            S_IDLE: ack_nxt = (state_nxt == S_ACK);
            S_ACK:  clr_cnt = 1'b1;
            S_RECV: begin
                if (rx_data_valid) begin
                    take_beat = 1'b1;
                    if (last_beat) begin
                        if (eff_len == LEN_W'(3)) load_op     = 1'b1;
                        else                      err_len_nxt = 1'b1;
                    end
                end else if (timed_out) begin
                    err_tmo_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered handshake and error pulses.
    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) begin
            rx_ack      <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            rx_ack      <= ack_nxt;
            err_len     <= err_len_nxt;
            err_timeout <= err_tmo_nxt;
        end
    end

    // Beat counter and inter-beat idle timer.
    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) begin
            beat_cnt <= '0;
            timer    <= '0;
        end else if (clr_cnt) begin
            beat_cnt <= '0;
            timer    <= '0;
        end else if (state == S_RECV) begin
            if (take_beat) begin
                beat_cnt <= beat_cnt + LEN_W'(1);
                timer    <= '0;
            end else begin
                timer    <= timer + TMR_W'(1);
            end
        end
    end

    // Staging for header and operands A/B; operand C is taken straight from
    // the final beat, as only a three-beat packet is ever published.
    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) begin
            stg_a   <= '0;
            stg_b   <= '0;
            stg_src <= '0;
            stg_len <= '0;
            stg_id  <= '0;
        end else if (take_beat) begin
            if (beat_cnt == '0) begin
                stg_src <= hdr_src;
                stg_len <= hdr_len;
                stg_id  <= hdr_id;
                stg_a   <= payload;
            end
            if (beat_cnt == LEN_W'(1)) stg_b <= payload;
        end
    end

    // Output slot: load on a good final beat, release after valid&&ready.
    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) begin
            op_a     <= '0;
            op_b     <= '0;
            op_c     <= '0;
            op_src   <= '0;
            op_id    <= '0;
            op_valid <= 1'b0;
        end else if (load_op) begin
            op_a     <= stg_a;
            op_b     <= stg_b;
            op_c     <= payload;
            op_src   <= stg_src;
            op_id    <= stg_id;
            op_valid <= 1'b1;
        end else if (op_valid && op_ready) begin
            op_valid <= 1'b0;
        end
    end

`ifdef NODE_RX_ERR_CNT_EN
    // Saturating count of discarded packets.
    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst)
            err_count <= '0;
        else if ((err_len || err_timeout) && (err_count != {CNT_W{1'b1}}))
            err_count <= err_count + CNT_W'(1);
    end
`else
    assign err_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_node_rx_collector.sv
// Directed self-checking bench for node_rx_collector (TIMEOUT=4).
module tb_node_rx_collector;

`ifdef NODE_RX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        N_clk;
    logic        N_rst;
    logic        rx_req;
    logic        rx_ack;
    logic [63:0] rx_data;
    logic        rx_data_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_c;
    logic [7:0]  op_src;
    logic [5:0]  op_id;
    logic        op_valid;
    logic        op_ready;
    logic        err_len;
    logic        err_timeout;
    logic [7:0]  err_count;

    int n_checks;
    int n_errors;

    node_rx_collector #(.TIMEOUT(4)) dut (
        .N_clk         (N_clk),
        .N_rst         (N_rst),
        .rx_req        (rx_req),
        .rx_ack        (rx_ack),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_c          (op_c),
        .op_src        (op_src),
        .op_id         (op_id),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .err_count     (err_count)
    );

    initial N_clk = 1'b0;
    always #5 N_clk = ~N_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_beat(input logic [7:0] src, input logic [5:0] len,
                                            input logic [5:0] id, input logic [31:0] pl);
        return {src, len, id, 12'h5A5, pl};
    endfunction

    task automatic tick();
        @(posedge N_clk);
        #1;
    endtask

    // Request, expect acknowledge one cycle later, then sit in RECV.
    task automatic start_pkt(input string tag);
        rx_req = 1'b1;
        tick();
        check(tag, 64'(rx_ack), 64'd1);
        rx_req = 1'b0;
        tick();
    endtask

    task automatic send_beat(input logic [63:0] d);
        rx_data       = d;
        rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        N_rst         = 1'b1;
        rx_req        = 1'b0;
        rx_data       = '0;
        rx_data_valid = 1'b0;
        op_ready      = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_ack",   64'(rx_ack),      64'd0);
        check("rst_valid", 64'(op_valid),    64'd0);
        check("rst_op_a",  64'(op_a),        64'd0);
        check("rst_src",   64'(op_src),      64'd0);
        check("rst_errl",  64'(err_len),     64'd0);
        check("rst_errt",  64'(err_timeout), 64'd0);
        check("rst_cnt",   64'(err_count),   64'd0);
        N_rst = 1'b0;
        tick();

        // Nominal packet; a beat offered during ACK must be ignored
        rx_req = 1'b1;
        tick();
        check("nom_ack", 64'(rx_ack), 64'd1);
        rx_req = 1'b0;
        rx_data       = mk_beat(8'd9, 6'd0, 6'd9, 32'hDEADBEEF);
        rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0;
        check("nom_ack_low", 64'(rx_ack), 64'd0);
        check("nom_ackbeat_errl", 64'(err_len), 64'd0);
        send_beat(mk_beat(8'd7, 6'd3, 6'd5, 32'h40200000));
        send_beat(mk_beat(8'd7, 6'd3, 6'd5, 32'h40800000));
        check("nom_valid_early", 64'(op_valid), 64'd0);
        send_beat(mk_beat(8'd7, 6'd3, 6'd5, 32'h3F900000));
        check("nom_valid", 64'(op_valid), 64'd1);
        check("nom_op_a",  64'(op_a),     64'h40200000);
        check("nom_op_b",  64'(op_b),     64'h40800000);
        check("nom_op_c",  64'(op_c),     64'h3F900000);
        check("nom_src",   64'(op_src),   64'd7);
        check("nom_id",    64'(op_id),    64'd5);

        // Backpressure: held set blocks the next acknowledge
        rx_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_no_ack", 64'(rx_ack),   64'd0);
            check("bp_hold",   64'(op_valid), 64'd1);
            check("bp_op_b",   64'(op_b),     64'h40800000);
        end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check("bp_valid_clr", 64'(op_valid), 64'd0);
        check("bp_ack_wait",  64'(rx_ack),   64'd0);
        tick();
        check("bp_ack", 64'(rx_ack), 64'd1);
        rx_req = 1'b0;
        tick();

        // Length error: seq_len=2
        send_beat(mk_beat(8'd3, 6'd2, 6'd1, 32'h1));
        send_beat(mk_beat(8'd3, 6'd2, 6'd1, 32'h2));
        check("len2_errl",  64'(err_len),  64'd1);
        check("len2_valid", 64'(op_valid), 64'd0);
        tick();
        check("len2_errl_off", 64'(err_len),   64'd0);
        check("len2_cnt",      64'(err_count), CNT_EN ? 64'd1 : 64'd0);

        // Length error: seq_len=5, flagged only after beat 4
        start_pkt("len5_ack");
        for (int k = 0; k < 4; k++) send_beat(mk_beat(8'd4, 6'd5, 6'd2, 32'(k)));
        check("len5_errl_early", 64'(err_len), 64'd0);
        send_beat(mk_beat(8'd4, 6'd5, 6'd2, 32'd4));
        check("len5_errl",  64'(err_len),  64'd1);
        check("len5_valid", 64'(op_valid), 64'd0);

        // Timeout after one beat and 4 idle edges
        start_pkt("tmo_ack");
        send_beat(mk_beat(8'd5, 6'd3, 6'd3, 32'hAAAA0000));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("tmo_early", 64'(err_timeout), 64'd0);
        end
        tick();
        check("tmo_pulse", 64'(err_timeout), 64'd1);
        tick();
        check("tmo_pulse_off", 64'(err_timeout), 64'd0);
        check("tmo_cnt", 64'(err_count), CNT_EN ? 64'd3 : 64'd0);

        // Next packet after timeout; headers on later beats are ignored
        start_pkt("post_tmo_ack");
        send_beat(mk_beat(8'h12, 6'd3, 6'h2A, 32'h11111111));
        send_beat(mk_beat(8'hFF, 6'd7, 6'd1,  32'h22222222));
        send_beat(mk_beat(8'hFF, 6'd7, 6'd1,  32'h33333333));
        check("p2_valid", 64'(op_valid), 64'd1);
        check("p2_op_a",  64'(op_a),     64'h11111111);
        check("p2_op_c",  64'(op_c),     64'h33333333);
        check("p2_src",   64'(op_src),   64'h12);
        check("p2_id",    64'(op_id),    64'h2A);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check("p2_consumed", 64'(op_valid), 64'd0);

        // Asynchronous reset mid-packet
        start_pkt("rstmid_ack");
        send_beat(mk_beat(8'd6, 6'd3, 6'd6, 32'h0BADF00D));
        send_beat(mk_beat(8'd6, 6'd3, 6'd6, 32'h0BADF00E));
        #2;
        N_rst = 1'b1;
        #1;
        check("rstmid_op_a",  64'(op_a),        64'd0);
        check("rstmid_op_c",  64'(op_c),        64'd0);
        check("rstmid_src",   64'(op_src),      64'd0);
        check("rstmid_id",    64'(op_id),       64'd0);
        check("rstmid_valid", 64'(op_valid),    64'd0);
        check("rstmid_errl",  64'(err_len),     64'd0);
        check("rstmid_errt",  64'(err_timeout), 64'd0);
        check("rstmid_cnt",   64'(err_count),   64'd0);
        tick();
        N_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rstmid_no_errt", 64'(err_timeout), 64'd0);
        end

        // Counter saturation with 260 zero-length packets
        for (int k = 0; k < 260; k++) begin
            start_pkt("sat_ack");
            send_beat(mk_beat(8'd1, 6'd0, 6'd0, 32'(k)));
        end
        check("sat_errl", 64'(err_len), 64'd1);
        tick();
        tick();
        check("sat_cnt",   64'(err_count), CNT_EN ? 64'd255 : 64'd0);
        check("sat_valid", 64'(op_valid),  64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
